// File: rtl/uart_rx_sampler_if.sv
// rtl/uart_rx_sampler_if.sv - received-byte handshake and status pulses of the UART receive sampler
// Optional parity error output exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_sampler_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (output rx_data, rx_valid, frame_err, overrun, busy, parity_err, input rx_ready);
  modport slave  (input rx_data, rx_valid, frame_err, overrun, busy, parity_err, output rx_ready);
`else
  modport master (output rx_data, rx_valid, frame_err, overrun, busy, input rx_ready);
  modport slave  (input rx_data, rx_valid, frame_err, overrun, busy, output rx_ready);
`endif
endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - 16x oversampled UART receiver with majority-vote bit recovery
// Parity checking is built in when UART_RX_PARITY_EN is defined.
module uart_rx_sampler #(
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 cfg_en,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 cfg_stop_bits,
`ifdef UART_RX_PARITY_EN
  input  logic [1:0]           cfg_parity,
`endif
  uart_rx_sampler_if.master    rx_if
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;
`endif

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [DIV_WIDTH-1:0]   div_cnt;
  logic [3:0]             sample_cnt;
  logic [2:0]             bit_idx;
  logic [1:0]             votes;
  logic [7:0]             shreg;
  logic                   tick, mid, end_bit, maj;
  logic                   complete, frame_set, discard;
  logic [7:0]             data_q;
  logic                   valid_q, frame_q, overrun_q;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign tick    = (state_q != S_IDLE) && (div_cnt == cfg_div);
  assign mid     = tick && (sample_cnt == 4'd9);
  assign end_bit = tick && (sample_cnt == 4'd15);
  // Samples 7 and 8 are held; the third vote is the live line at sample 9.
  assign maj     = (votes[0] & votes[1]) | (votes[0] & rx_s) | (votes[1] & rx_s);

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_set, par_q, parity_on;
  assign parity_on = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
  assign discard   = par_bad;
`else
  assign discard   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    complete  = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set   = 1'b0;
`endif
    if (!cfg_en && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      if (cfg_en && !rx_s) state_d = S_START;
        S_START: begin
          if (mid && maj) state_d = S_IDLE;
          else if (end_bit) state_d = S_DATA;
        end
        S_DATA: begin
          if (end_bit && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = parity_on ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (end_bit) begin
            par_set = par_bad;
            state_d = S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (mid) begin
            if (!maj) begin
              frame_set = 1'b1;
              state_d   = S_WAIT_IDLE;
            end else if (!cfg_stop_bits || bit_idx[0]) begin
              complete = !discard;
              state_d  = S_IDLE;
            end
          end
        end
        S_WAIT_IDLE: if (rx_s) state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '1;
      div_cnt    <= '0;
      sample_cnt <= '0;
      bit_idx    <= '0;
      votes      <= '0;
      shreg      <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      if (state_q == S_IDLE) begin
        div_cnt    <= '0;
        sample_cnt <= '0;
        bit_idx    <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) sample_cnt <= sample_cnt + 4'd1;
        // Bit index wraps 7->0 leaving DATA, then marks the second stop bit.
        if (end_bit && (state_q == S_DATA || state_q == S_STOP)) bit_idx <= bit_idx + 3'd1;
      end
      if (tick && sample_cnt == 4'd7) votes[0] <= rx_s;
      if (tick && sample_cnt == 4'd8) votes[1] <= rx_s;
      if (state_q == S_DATA && mid) shreg <= {maj, shreg[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      par_q <= par_set;
      if (state_q == S_IDLE) par_bad <= 1'b0;
      else if (state_q == S_PARITY && mid) par_bad <= (^shreg) ^ maj ^ cfg_parity[1];
    end
  end
  assign rx_if.parity_err = par_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      frame_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      frame_q   <= frame_set;
      overrun_q <= complete && valid_q && !rx_if.rx_ready;
      if (complete && (!valid_q || rx_if.rx_ready)) begin
        data_q  <= shreg;
        valid_q <= 1'b1;
      end else if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data   = data_q;
  assign rx_if.rx_valid  = valid_q;
  assign rx_if.frame_err = frame_q;
  assign rx_if.overrun   = overrun_q;
  assign rx_if.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb/tb_uart_rx_sampler.sv - directed self-checking bench for uart_rx_sampler
// Parity vectors are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_sampler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        cfg_en = 1'b0;
  logic [15:0] cfg_div = 16'd0;
  logic        cfg_stop_bits = 1'b0;
  logic        rx_ready = 1'b1;
`ifdef UART_RX_PARITY_EN
  logic [1:0]  cfg_parity = 2'b00;
`endif

  uart_rx_sampler_if rx_if ();
  assign rx_if.rx_ready = rx_ready;

  uart_rx_sampler #(.DIV_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .cfg_en        (cfg_en),
    .cfg_div       (cfg_div),
    .cfg_stop_bits (cfg_stop_bits),
`ifdef UART_RX_PARITY_EN
    .cfg_parity    (cfg_parity),
`endif
    .rx_if         (rx_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int acc_cnt = 0, valid_hi_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
  logic [7:0] acc_data = 8'h00;
  int a0, v0, f0, o0, p0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_if.rx_valid) valid_hi_cnt++;
      if (rx_if.rx_valid && rx_ready) begin
        acc_cnt++;
        acc_data = rx_if.rx_data;
      end
      if (rx_if.frame_err) ferr_cnt++;
      if (rx_if.overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (rx_if.parity_err) perr_cnt++;
`endif
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    a0 = acc_cnt; v0 = valid_hi_cnt; f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_data(input logic [7:0] d);
    int bp;
    bp = 16 * (int'(cfg_div) + 1);
    drive_bit(1'b0, bp);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bp);
  endtask

  task automatic send_frame(input logic [7:0] d, input int par, input logic s1, input logic s2);
    int bp;
    bp = 16 * (int'(cfg_div) + 1);
    send_data(d);
    if (par >= 0) drive_bit(par[0], bp);
    drive_bit(s1, bp);
    if (cfg_stop_bits) drive_bit(s2, bp);
    rx = 1'b1;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 rx_ready = r;
    @(negedge clk);
  endtask

  initial begin
    int waited;
    repeat (4) @(negedge clk);
    check_eq("reset_valid", rx_if.rx_valid, 0);
    check_eq("reset_data", rx_if.rx_data, 0);
    check_eq("reset_busy", rx_if.busy, 0);
    check_eq("reset_frame_err", rx_if.frame_err, 0);
    check_eq("reset_overrun", rx_if.overrun, 0);
    rst = 1'b0;
    cfg_en = 1'b1;
    idle(8);

    // single byte at 16 clk/bit
    snap();
    send_frame(8'hA5, -1, 1'b1, 1'b1);
    idle(6);
    check_eq("t1_accept_cnt", acc_cnt - a0, 1);
    check_eq("t1_data", acc_data, 8'hA5);
    check_eq("t1_valid_width", valid_hi_cnt - v0, 1);
    check_eq("t1_frame_err", ferr_cnt - f0, 0);

    // back-to-back with downstream stalled
    cfg_div = 16'd3;
    set_ready(1'b0);
    snap();
    send_frame(8'h3C, -1, 1'b1, 1'b1);
    send_frame(8'h81, -1, 1'b1, 1'b1);
    idle(10);
    check_eq("t2_valid_held", rx_if.rx_valid, 1);
    check_eq("t2_data_held", rx_if.rx_data, 8'h3C);
    check_eq("t2_overrun_cnt", ovr_cnt - o0, 1);
    check_eq("t2_frame_err", ferr_cnt - f0, 0);
    set_ready(1'b1);
    idle(2);
    check_eq("t2_drain_data", acc_data, 8'h3C);
    check_eq("t2_drain_cnt", acc_cnt - a0, 1);
    check_eq("t2_valid_clear", rx_if.rx_valid, 0);

    // short low glitch is rejected
    cfg_div = 16'd0;
    idle(4);
    snap();
    drive_bit(1'b0, 4);
    check_eq("t3_busy_rise", rx_if.busy, 1);
    rx = 1'b1;
    waited = 0;
    while (rx_if.busy && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    check_eq("t3_busy_fall", rx_if.busy, 0);
    idle(20);
    check_eq("t3_no_byte", acc_cnt - a0, 0);
    check_eq("t3_no_frame_err", ferr_cnt - f0, 0);

    // stop bit low, break held, then recovery
    snap();
    send_data(8'h55);
    drive_bit(1'b0, 40);
    check_eq("t4_wait_idle_busy", rx_if.busy, 1);
    check_eq("t4_frame_err", ferr_cnt - f0, 1);
    check_eq("t4_no_byte", acc_cnt - a0, 0);
    idle(8);
    check_eq("t4_idle_after_rise", rx_if.busy, 0);
    send_frame(8'h12, -1, 1'b1, 1'b1);
    idle(6);
    check_eq("t4_next_cnt", acc_cnt - a0, 1);
    check_eq("t4_next_data", acc_data, 8'h12);

    // two stop bits
    cfg_div = 16'd1;
    cfg_stop_bits = 1'b1;
    snap();
    send_frame(8'h7E, -1, 1'b1, 1'b0);
    idle(10);
    check_eq("t5_frame_err", ferr_cnt - f0, 1);
    check_eq("t5_no_byte", acc_cnt - a0, 0);
    snap();
    send_frame(8'h7E, -1, 1'b1, 1'b1);
    idle(10);
    check_eq("t5_ok_cnt", acc_cnt - a0, 1);
    check_eq("t5_ok_data", acc_data, 8'h7E);
    check_eq("t5_ok_frame_err", ferr_cnt - f0, 0);
    cfg_stop_bits = 1'b0;

    // enable dropped mid-frame
    cfg_div = 16'd0;
    snap();
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 40);
    cfg_en = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("t7_disable_busy", rx_if.busy, 0);
    cfg_en = 1'b1;
    idle(200);
    check_eq("t7_disable_no_byte", acc_cnt - a0, 0);
    check_eq("t7_disable_no_frame_err", ferr_cnt - f0, 0);

`ifdef UART_RX_PARITY_EN
    // even parity on 0x07 (three ones) needs parity bit 1
    cfg_parity = 2'b01;
    snap();
    send_frame(8'h07, 0, 1'b1, 1'b1);
    idle(6);
    check_eq("t6_parity_err", perr_cnt - p0, 1);
    check_eq("t6_bad_no_byte", acc_cnt - a0, 0);
    check_eq("t6_bad_frame_err", ferr_cnt - f0, 0);
    snap();
    send_frame(8'h07, 1, 1'b1, 1'b1);
    idle(6);
    check_eq("t6_good_cnt", acc_cnt - a0, 1);
    check_eq("t6_good_data", acc_data, 8'h07);
    check_eq("t6_good_no_parity_err", perr_cnt - p0, 0);
    cfg_parity = 2'b00;
`endif

    // reset mid-frame returns everything to idle
    send_data(8'hFF);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t8_reset_busy", rx_if.busy, 0);
    check_eq("t8_reset_valid", rx_if.rx_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
Serial-line receive front end for the UART peripheral. It sits directly upstream of the receive FIFO and deserialises the asynchronous `uart_rx_i` pin into bytes. The pin is synchronised and oversampled 16x, and each bit is resolved by a majority vote. Completed bytes are presented on a valid/ready interface that feeds the FIFO write port, and framing and overrun conditions are reported as single-cycle pulses.

Parameters:
- DIV_WIDTH, 16, width of the oversample divisor input.
- SYNC_STAGES, 2, number of flops in the `rx_i` synchroniser (minimum 2).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- rx_i  input  1  asynchronous serial line; idles high
- cfg_en_i  input  1  receiver enable
- cfg_div_i  input  DIV_WIDTH  oversample tick period minus 1, in clk cycles
- cfg_stop_bits_i  input  1  0 = one stop bit, 1 = two stop bits
- rx_data_o  output  8  received byte
- rx_valid_o  output  1  `rx_data_o` holds an unconsumed byte
- rx_ready_i  input  1  downstream (FIFO) accepts the byte
- frame_err_o  output  1  one-cycle pulse: a stop bit was sampled low
- overrun_o  output  1  one-cycle pulse: a frame completed while `rx_valid_o`=1
- busy_o  output  1  high whenever the state is not IDLE

Behaviour:
- Reset values:
  - synchroniser flops = 1.
  - `rx_data_o`=0, `rx_valid_o`=0, `frame_err_o`=0, `overrun_o`=0, `busy_o`=0.
  - state = IDLE; tick counter = 0; sample counter = 0.
- Synchroniser: `rx_s` is the output of the SYNC_STAGES flop chain, giving SYNC_STAGES cycles of pin-to-`rx_s` latency.
- Tick generator:
  - Counts 0..`cfg_div_i`, asserting `tick` when the count equals `cfg_div_i`, then wrapping to 0.
  - Runs only while state is not IDLE and is cleared to 0 in IDLE.
  - `cfg_div_i`=0 gives a tick every clk, i.e. 16 clk per bit.
- Sample counter: 4 bits, increments on each tick. Bit value = majority of `rx_s` sampled on ticks 7, 8 and 9.
- States:
  - IDLE: when `cfg_en_i`=1 and `rx_s`=0 -> START; counters cleared.
  - START: at tick 9, if the majority is 1 -> IDLE (glitch rejected, no pulses). At tick 15 -> DATA with bit index 0.
  - DATA: 8 bits, LSB first, shifted into an internal register. At tick 15 of bit 7 -> PARITY if the feature is enabled, else STOP.
  - STOP: the first stop bit is checked. If `cfg_stop_bits_i`=1, a second stop bit is also checked. A majority of 0 on any stop bit -> `frame_err_o` pulse, the byte is discarded, -> WAIT_IDLE. If every stop bit is 1, the frame completes at tick 9 of the final stop bit -> IDLE. Ending at mid-bit allows back-to-back frames.
  - WAIT_IDLE: stays until `rx_s`=1 (break tolerance) -> IDLE.
- Frame completion:
  - If `rx_valid_o`=0, or `rx_valid_o`=1 and `rx_ready_i`=1 in the same cycle: load `rx_data_o` and set `rx_valid_o`=1.
  - Otherwise: keep the old byte, pulse `overrun_o`, and drop the new byte.
- Output handshake: `rx_valid_o` clears on `rx_valid_o`&&`rx_ready_i` unless a new byte loads that same cycle. `rx_data_o` is stable while `rx_valid_o`=1.
- `cfg_en_i` falling mid-frame: next cycle -> IDLE, the partial byte is discarded, no pulses. A held `rx_valid_o` is unaffected.
- `cfg_div_i` must be static while `busy_o`=1. If it changes mid-frame, the result is undefined (no hang required beyond the current frame).
- Reset mid-frame: all state returns to reset values on the next clk.

Optional Feature:
Macro `UART_RX_PARITY_EN`.
- Defined:
  - Adds input `cfg_parity_i[1:0]`: 00 none, 01 even, 10 odd, 11 reserved (treated as none).
  - Adds output `parity_err_o` (one-cycle pulse).
  - When parity is enabled, the PARITY state samples one extra bit after bit 7.
  - On mismatch, `parity_err_o` pulses at tick 15 of the parity bit, the byte is discarded, and the receiver continues to STOP. A stop-bit error in the same frame also pulses `frame_err_o`.
- Undefined: no PARITY state, no extra ports, and DATA goes directly to STOP.

Test Plan:
1. `cfg_div_i`=0, one stop bit, send 0xA5 (16 clk/bit), `rx_ready_i`=1 -> `rx_valid_o` pulses 1 cycle with `rx_data_o`=0xA5, `frame_err_o`=0.
2. `cfg_div_i`=3, send 0x3C then 0x81 back-to-back with `rx_ready_i`=0 -> 0x3C is held, `overrun_o` pulses once at completion of 0x81, and `rx_data_o` stays 0x3C.
3. Low glitch on `rx_i` of 4 clk at `cfg_div_i`=0 -> returns to IDLE, `rx_valid_o` stays 0, `busy_o` falls within 10 tick periods.
4. Send 0x55 with the stop bit forced low, line held low 40 clk -> `frame_err_o` pulse, no `rx_valid_o`, stays in WAIT_IDLE until the line rises, then a following 0x12 is received correctly.
5. `cfg_stop_bits_i`=1: second stop bit low on 0x7E -> `frame_err_o`; repeat with both stop bits high -> 0x7E delivered.
6. `UART_RX_PARITY_EN`, even parity, 0x07 with parity bit 0 -> `parity_err_o` pulse, no byte; with parity bit 1 -> 0x07 delivered.
